// File: rtl/img_pkg.sv
// Shared widths, FSM state type and BMP row-stride helper for the image pipeline.
package img_pkg;

    localparam int unsigned PIX_W   = 8;
    localparam int unsigned COORD_W = 12;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } state_t;

    // BMP rows are padded to a multiple of 4 bytes.
    function automatic int unsigned img_stride(input int unsigned w);
        return ((w + 3) / 4) * 4;
    endfunction

endpackage

// File: rtl/pix_skid_fifo.sv
// Two-entry FIFO that buffers memory read data ahead of the pixel handshake.
module pix_skid_fifo #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_count;
    logic             w_wr;
    logic             w_rd;

    assign w_rd = i_pop && (r_count != 2'd0);
    assign w_wr = i_push && ((r_count != 2'd2) || w_rd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_wr) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= ~r_wptr;
            end
            if (w_rd) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/bmp_pixel_streamer.sv
// Streams the pixel bytes of an 8-bit BMP held in a synchronous-read byte memory.
// Define BMP_BOTTOM_UP_EN to fetch stored rows bottom-up so output is top-down.
module bmp_pixel_streamer
    import img_pkg::*;
#(
    parameter int unsigned IMG_W        = 256,
    parameter int unsigned IMG_H        = 256,
    parameter int unsigned HEADER_BYTES = 1078,
    parameter int unsigned ADDR_W       = 18
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               mem_rd_en,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [PIX_W-1:0]   mem_rdata,
    output logic [PIX_W-1:0]   pix_data,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               pix_eol,
    output logic               pix_last
);

    localparam int unsigned        STRIDE = img_stride(IMG_W);
    localparam logic [COORD_W-1:0] LAST_X = COORD_W'(IMG_W - 1);
    localparam logic [COORD_W-1:0] LAST_Y = COORD_W'(IMG_H - 1);
`ifdef BMP_BOTTOM_UP_EN
    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(HEADER_BYTES + (IMG_H - 1) * STRIDE);
    // Two's-complement step back to the start of the previous stored row.
    localparam logic [ADDR_W-1:0] ROW_JUMP   = ADDR_W'(0 - (STRIDE + IMG_W - 1));
`else
    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(HEADER_BYTES);
    localparam logic [ADDR_W-1:0] ROW_JUMP   = ADDR_W'(STRIDE - IMG_W + 1);
`endif

    state_t             r_state;
    logic               r_busy;
    logic               r_done;
    logic               r_inflight;
    logic [ADDR_W-1:0]  r_addr;
    logic [COORD_W-1:0] r_rd_x;
    logic [COORD_W-1:0] r_rd_r;
    logic [COORD_W-1:0] r_ox;
    logic [COORD_W-1:0] r_oy;
    logic [1:0]         w_count;
    logic               w_pop;
    logic               w_issue;
    logic               w_rd_last;

    assign pix_valid = (w_count != 2'd0);
    assign w_pop     = pix_valid && pix_ready;
    // Keep buffered + in-flight bytes at most 2 after the coming edge.
    assign w_issue   = (r_state == FETCH) &&
                       ((({1'b0, w_count} + {2'b00, r_inflight}) - {2'b00, w_pop}) < 3'd2);
    assign w_rd_last = (r_rd_x == LAST_X) && (r_rd_r == LAST_Y);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_inflight <= 1'b0;
            r_addr     <= '0;
            r_rd_x     <= '0;
            r_rd_r     <= '0;
            r_ox       <= '0;
            r_oy       <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_pop) begin
                if (r_ox == LAST_X) begin
                    r_ox <= '0;
                    r_oy <= (r_oy == LAST_Y) ? '0 : r_oy + COORD_W'(1);
                end else begin
                    r_ox <= r_ox + COORD_W'(1);
                end
            end
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= FETCH;
                        r_busy  <= 1'b1;
                        r_addr  <= FIRST_ADDR;
                        r_rd_x  <= '0;
                        r_rd_r  <= '0;
                        r_ox    <= '0;
                        r_oy    <= '0;
                    end
                end
                FETCH: begin
                    if (w_issue) begin
                        if (r_rd_x == LAST_X) begin
                            r_rd_x <= '0;
                            r_rd_r <= r_rd_r + COORD_W'(1);
                            r_addr <= r_addr + ROW_JUMP;
                        end else begin
                            r_rd_x <= r_rd_x + COORD_W'(1);
                            r_addr <= r_addr + ADDR_W'(1);
                        end
                        if (w_rd_last) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_pop && pix_last) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    pix_skid_fifo #(
        .WIDTH(PIX_W)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_push (r_inflight),
        .i_data (mem_rdata),
        .i_pop  (w_pop),
        .o_data (pix_data),
        .o_count(w_count)
    );

    assign busy      = r_busy;
    assign done      = r_done;
    assign mem_rd_en = w_issue;
    assign mem_addr  = r_addr;
    assign pix_x     = r_ox;
    assign pix_y     = r_oy;
    assign pix_eol   = pix_valid && (r_ox == LAST_X);
    assign pix_last  = pix_eol && (r_oy == LAST_Y);

endmodule

// File: tb/tb_bmp_pixel_streamer.sv
// Self-checking bench for bmp_pixel_streamer: 6x2 image with padding plus a 4x3 unpadded image.
`timescale 1ns/1ps
module tb_bmp_pixel_streamer;

    localparam int unsigned W  = 6;
    localparam int unsigned H  = 2;
    localparam int unsigned HB = 4;
    localparam int unsigned ST = 8;
    localparam int unsigned AW = 8;
    localparam int unsigned W4 = 4;
    localparam int unsigned H4 = 3;

    typedef struct {
        logic [7:0]  data;
        logic [11:0] x;
        logic [11:0] y;
        logic        eol;
        logic        last;
    } exp_t;

    typedef struct {
        logic [3:0] ready_pat;
        int         restart_cyc;
        int         exp_pixels;
        int         exp_dones;
        int         exp_done_lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic pix_ready = 1'b0;
    logic busy, done, mem_rd_en, pix_valid, pix_eol, pix_last;
    logic [AW-1:0] mem_addr;
    logic [7:0] mem_rdata, pix_data;
    logic [11:0] pix_x, pix_y;

    logic start4 = 1'b0;
    logic busy4, done4, rd_en4, valid4, eol4, last4;
    logic [AW-1:0] addr4;
    logic [7:0] rdata4, data4;
    logic [11:0] x4, y4;

    int checks = 0;
    int failures = 0;
    exp_t sb_q[$];
    int addr_q[$];
    int addr4_q[$];
    int hs_cnt, done_cnt, issued, pops, hs4_cnt, done4_cnt;
    logic prev_stall = 1'b0;
    logic [33:0] prev_payload;

    always #5 clk = ~clk;

    bmp_pixel_streamer #(
        .IMG_W(W), .IMG_H(H), .HEADER_BYTES(HB), .ADDR_W(AW)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_eol(pix_eol), .pix_last(pix_last)
    );

    bmp_pixel_streamer #(
        .IMG_W(W4), .IMG_H(H4), .HEADER_BYTES(HB), .ADDR_W(AW)
    ) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .busy(busy4), .done(done4),
        .mem_rd_en(rd_en4), .mem_addr(addr4), .mem_rdata(rdata4),
        .pix_data(data4), .pix_valid(valid4), .pix_ready(1'b1),
        .pix_x(x4), .pix_y(y4), .pix_eol(eol4), .pix_last(last4)
    );

    function automatic logic [7:0] mem_f(input int a);
        return 8'(a * 37 + 11);
    endfunction

    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem_f(int'(mem_addr));
        if (rd_en4) rdata4 <= mem_f(int'(addr4));
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int stored_row(input int y, input int h);
`ifdef BMP_BOTTOM_UP_EN
        return h - 1 - y;
`else
        return y;
`endif
    endfunction

    task automatic push_expected();
        exp_t e;
        int a;
        for (int i = 0; i < int'(W * H); i++) begin
            e.x    = 12'(i % W);
            e.y    = 12'(i / W);
            a      = HB + stored_row(i / W, H) * ST + (i % W);
            e.data = mem_f(a);
            e.eol  = ((i % W) == W - 1);
            e.last = (i == W * H - 1);
            sb_q.push_back(e);
            addr_q.push_back(a);
        end
    endtask

    // Output-side monitor: addresses, scoreboard pops, stall stability, occupancy.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_rd_en) begin
                issued++;
                if (addr_q.size() == 0) chk("unexpected_read", int'(mem_addr), -1);
                else chk("mem_addr", int'(mem_addr), addr_q.pop_front());
            end
            if (prev_stall) begin
                chk("stall_valid", pix_valid, 1);
                chk("stall_payload", {pix_data, pix_x, pix_y, pix_eol, pix_last}, prev_payload);
            end
            if (pix_valid && pix_ready) begin
                exp_t e;
                pops++;
                hs_cnt++;
                if (sb_q.size() == 0) chk("unexpected_pixel", pix_data, -1);
                else begin
                    e = sb_q.pop_front();
                    chk("pixel", {pix_data, pix_x, pix_y, pix_eol, pix_last},
                        {e.data, e.x, e.y, e.eol, e.last});
                end
            end
            if (mem_rd_en || (pix_valid && pix_ready)) chk("occupancy_le2", (issued - pops) <= 2, 1);
            prev_stall   = pix_valid && !pix_ready;
            prev_payload = {pix_data, pix_x, pix_y, pix_eol, pix_last};
            if (done) done_cnt++;
            if (rd_en4) begin
                if (addr4_q.size() == 0) chk("unexpected_read4", int'(addr4), -1);
                else chk("mem_addr4", int'(addr4), addr4_q.pop_front());
            end
            if (valid4) begin
                int a;
                a = HB + stored_row(hs4_cnt / W4, H4) * W4 + (hs4_cnt % W4);
                chk("pixel4", {data4, x4, y4, eol4, last4},
                    {mem_f(a), 12'(hs4_cnt % W4), 12'(hs4_cnt / W4),
                     ((hs4_cnt % W4) == W4 - 1), (hs4_cnt == W4 * H4 - 1)});
                hs4_cnt++;
            end
            if (done4) done4_cnt++;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic run_frame(input vec_t v);
        int k;
        logic got_done;
        push_expected();
        hs_cnt   = 0;
        done_cnt = 0;
        got_done = 1'b0;
        k        = 0;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        pix_ready = v.ready_pat[0];
        while (!got_done && k < 300) begin
            start = (k == v.restart_cyc);
            @(posedge clk);
            #1;
            k++;
            pix_ready = v.ready_pat[k % 4];
            if (v.exp_done_lat >= 0 && k == 1) chk("valid_before_lat", pix_valid, 0);
            if (v.exp_done_lat >= 0 && k == 2) chk("first_valid_lat", pix_valid, 1);
            if (done) begin
                got_done = 1'b1;
                if (v.exp_done_lat >= 0) chk("done_latency", k, v.exp_done_lat);
            end
        end
        start = 1'b0;
        chk("done_seen", got_done, 1);
        repeat (4) @(posedge clk);
        #1;
        chk("busy_after", busy, 0);
        chk("done_pulses", done_cnt, v.exp_dones);
        chk("pixel_count", hs_cnt, v.exp_pixels);
        chk("sb_empty", sb_q.size(), 0);
        chk("addr_q_empty", addr_q.size(), 0);
    endtask

    vec_t vecs[4];

    initial begin
        int n;
        vecs[0] = '{4'b1111, -1, 12, 1, 14};
        vecs[1] = '{4'b1001, -1, 12, 1, -1};
        vecs[2] = '{4'b1111, 5, 12, 1, 14};
        vecs[3] = '{4'b0110, -1, 12, 1, -1};
        issued = 0; pops = 0; hs4_cnt = 0; done4_cnt = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {busy, done, mem_rd_en, mem_addr, pix_data, pix_valid, pix_x,
                              pix_y, pix_eol, pix_last}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++) run_frame(vecs[i]);

        // Mid-frame reset after five pixels.
        push_expected();
        hs_cnt    = 0;
        done_cnt  = 0;
        pix_ready = 1'b1;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (hs_cnt < 5 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("five_pixels_seen", hs_cnt, 5);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_mid_outputs", {busy, done, mem_rd_en, mem_addr, pix_data, pix_valid, pix_x,
                                  pix_y, pix_eol, pix_last}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb_q.delete();
        addr_q.delete();
        issued = 0;
        pops   = 0;
        repeat (5) @(posedge clk);
        #1;
        chk("no_done_after_reset", done_cnt, 0);
        chk("busy_after_reset", busy, 0);
        run_frame(vecs[0]);

        // Unpadded 4-wide image on the second instance.
        for (int i = 0; i < int'(W4 * H4); i++)
            addr4_q.push_back(HB + stored_row(i / W4, H4) * W4 + (i % W4));
        start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        n = 0;
        while (done4_cnt == 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("done4_pulses", done4_cnt, 1);
        chk("pixel4_count", hs4_cnt, W4 * H4);
        chk("addr4_q_empty", addr4_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
